// File: rtl/t_count_ctrl.sv
// t_count_ctrl: control sequencer for a WIDTH-bit T-flip-flop counter.
// Owns the count register and produces the per-bit toggle vector, with
// start/stop/resume, up/down, load/terminal values and one-shot or
// auto-reload operation. Every output is registered.
module t_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONES = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] t_reg, t_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             wrap_reg, wrap_next;

  // Next-state, next-count and pulse decode; RUN follows stop > terminal > count priority.
  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    done_next  = 1'b0;
    wrap_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          q_next     = load_val;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_HOLD;
        end else if (q_reg == term_val) begin
          done_next = 1'b1;
          if (auto_reload) begin
            q_next = load_val;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (dir) begin
          q_next    = q_reg + CNT_ONE;
          wrap_next = (q_reg == CNT_ONES);
        end else begin
          q_next    = q_reg - CNT_ONE;
          wrap_next = (q_reg == CNT_ZERO);
        end
      end
      ST_HOLD: begin
        // Resume keeps the frozen count; stop dominates a simultaneous start.
        if (!stop && start) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    busy_next = (state_next == ST_RUN) || (state_next == ST_HOLD);
  end

  // Toggle vector: one T input per counter bit, set where the bit changes.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_toggle
      assign t_next[gi] = q_next[gi] ^ q_reg[gi];
    end
  endgenerate

  // State and output registers; reset clears everything without pulsing done/wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      q_reg     <= CNT_ZERO;
      t_reg     <= CNT_ZERO;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      t_reg     <= t_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign q    = q_reg;
  assign t    = t_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_t_count_ctrl.sv
// Testbench for t_count_ctrl: directed scenarios plus randomized stimulus,
// checked against a mode/count reference model and against fixed expectations.
module tb_t_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b1;
  logic       auto_reload = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] term_val = 4'd0;
  logic [3:0] q, t;
  logic       busy, done, wrap;

  int vecs = 0;
  int miscompares = 0;

  // Reference model: mode 0 = idle, 1 = counting, 2 = paused.
  int         m_mode = 0;
  logic [3:0] m_q = 4'd0;
  logic [3:0] m_t = 4'd0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_wrap = 1'b0;

  t_count_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
    .auto_reload(auto_reload), .load_val(load_val), .term_val(term_val),
    .q(q), .t(t), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Apply one clock edge with the currently driven inputs and advance the model.
  task automatic step();
    logic [3:0] old_q;
    @(posedge clk);
    old_q  = m_q;
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_q    = 4'd0;
      m_t    = 4'd0;
      m_busy = 1'b0;
    end else begin
      if (m_mode == 0) begin
        if (start) begin
          m_q = load_val;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (stop) m_mode = 2;
        else if (m_q == term_val) begin
          m_done = 1'b1;
          if (auto_reload) m_q = load_val;
          else m_mode = 0;
        end else if (dir) begin
          m_wrap = (m_q == 4'd15);
          m_q = 4'((int'(m_q) + 1) % 16);
        end else begin
          m_wrap = (m_q == 4'd0);
          m_q = 4'((int'(m_q) + 15) % 16);
        end
      end else begin
        if (!stop && start) m_mode = 1;
      end
      m_t    = m_q ^ old_q;
      m_busy = (m_mode != 0);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; load_val = 4'd9;
    for (int i = 0; i < 2; i++) begin
      step();
      vecs++;
      if ({q, t, busy, done, wrap} !== 11'd0) begin
        miscompares++;
        $display("FAIL reset cyc%0d: q=%h t=%h busy=%b done=%b wrap=%b required all 0", i, q, t, busy, done, wrap);
      end
    end
    start = 1'b0; rst = 1'b0;
    step();
    vecs++;
    if (busy !== 1'b0 || q !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b q=%h required busy=0 q=0", busy, q);
    end
  endtask

  task automatic test_oneshot_up();
    logic [3:0] exp_q [7] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd7};
    logic       exp_d [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_b [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    load_val = 4'd3; term_val = 4'd7; dir = 1'b1; auto_reload = 1'b0;
    for (int i = 0; i < 7; i++) begin
      start = (i == 0);
      step();
      vecs++;
      if (q !== exp_q[i] || done !== exp_d[i] || busy !== exp_b[i]) begin
        miscompares++;
        $display("FAIL oneshot_up e%0d: q=%h done=%b busy=%b required q=%h done=%b busy=%b", i, q, done, busy, exp_q[i], exp_d[i], exp_b[i]);
      end
      if (i == 1) begin
        vecs++;
        if (t !== 4'b0111) begin
          miscompares++;
          $display("FAIL oneshot_up_t: t=%b required 0111", t);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_q [6] = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14, 4'd14};
    logic       exp_w [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_d [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    load_val = 4'd2; term_val = 4'd14; dir = 1'b0; auto_reload = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start = (i == 0);
      step();
      vecs++;
      if (q !== exp_q[i] || wrap !== exp_w[i] || done !== exp_d[i]) begin
        miscompares++;
        $display("FAIL down_wrap e%0d: q=%h wrap=%b done=%b required q=%h wrap=%b done=%b", i, q, wrap, done, exp_q[i], exp_w[i], exp_d[i]);
      end
      if (i == 3) begin
        vecs++;
        if (t !== 4'b1111) begin
          miscompares++;
          $display("FAIL down_wrap_t: t=%b required 1111", t);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_stop_resume();
    // stimulus rows: {start, stop}; expected q and busy after each edge
    logic [1:0] stim  [9] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00};
    logic [3:0] exp_q [9] = '{4'd3, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6, 4'd7};
    load_val = 4'd3; term_val = 4'd12; dir = 1'b1; auto_reload = 1'b0;
    for (int i = 0; i < 9; i++) begin
      start = stim[i][1];
      stop  = stim[i][0];
      step();
      vecs++;
      if (q !== exp_q[i] || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL stop_resume e%0d: q=%h busy=%b required q=%h busy=1", i, q, busy, exp_q[i]);
      end
      if (i >= 3 && i <= 6) begin
        vecs++;
        if (t !== 4'd0) begin
          miscompares++;
          $display("FAIL stop_resume_t e%0d: t=%b required 0000", i, t);
        end
      end
    end
    start = 1'b0; stop = 1'b0;
    // reset mid-count clears everything at that edge
    rst = 1'b1;
    step();
    vecs++;
    if ({q, t, busy, done, wrap} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_midcount: q=%h t=%h busy=%b done=%b wrap=%b required all 0", q, t, busy, done, wrap);
    end
    rst = 1'b0;
  endtask

  task automatic test_auto_reload();
    logic [3:0] exp_q [10] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd14, 4'd15, 4'd0, 4'd1, 4'd14, 4'd15};
    load_val = 4'd14; term_val = 4'd1; dir = 1'b1; auto_reload = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 0);
      step();
      vecs++;
      if (q !== exp_q[i] || busy !== 1'b1 || done !== (i == 4 || i == 8) || wrap !== (i == 2 || i == 6)) begin
        miscompares++;
        $display("FAIL auto_reload e%0d: q=%h busy=%b done=%b wrap=%b required q=%h busy=1 done=%b wrap=%b", i, q, busy, done, wrap, exp_q[i], (i == 4 || i == 8), (i == 2 || i == 6));
      end
    end
    start = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; auto_reload = 1'b0;
  endtask

  task automatic test_equal_load_term();
    load_val = 4'd9; term_val = 4'd9; dir = 1'b1; auto_reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    vecs++;
    if (q !== 4'd9 || busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL equal_load: q=%h busy=%b done=%b required q=9 busy=1 done=0", q, busy, done);
    end
    step();
    vecs++;
    if (q !== 4'd9 || busy !== 1'b0 || done !== 1'b1 || t !== 4'd0) begin
      miscompares++;
      $display("FAIL equal_term: q=%h busy=%b done=%b t=%b required q=9 busy=0 done=1 t=0000", q, busy, done, t);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      start       = ($urandom_range(0, 3) == 0);
      stop        = ($urandom_range(0, 7) == 0);
      dir         = ($urandom_range(0, 9) != 0) ? dir : ~dir;
      auto_reload = ($urandom_range(0, 19) == 0) ? ~auto_reload : auto_reload;
      if ($urandom_range(0, 9) == 0) load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) term_val = 4'($urandom_range(0, 15));
      step();
      vecs++;
      if ({q, t, busy, done, wrap} !== {m_q, m_t, m_busy, m_done, m_wrap}) begin
        miscompares++;
        $display("FAIL random c%0d: q=%h t=%h busy=%b done=%b wrap=%b required q=%h t=%h busy=%b done=%b wrap=%b",
                 i, q, t, busy, done, wrap, m_q, m_t, m_busy, m_done, m_wrap);
      end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot_up();
    test_down_wrap();
    test_stop_resume();
    test_auto_reload();
    test_equal_load_term();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/t_count_ctrl.md
# t_count_ctrl

Synchronous sequencer for a 4-bit T-flip-flop counter. It owns the count register and drives the per-bit toggle vector, adding start/stop/resume control, up/down direction, a programmable load value and terminal value, and one-shot or auto-reload operation. It is the control front end for the counter datapath. All state changes occur on the single clock edge, with no rippled clocking.

## Interface
- WIDTH, 4, counter width. The design is verified only at 4.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  level-sampled; loads or resumes the count (see Operation)
- stop  input  1  level-sampled; pauses a running count
- dir  input  1  1 = count up, 0 = count down; sampled every RUN cycle
- auto_reload  input  1  1 = reload load_val at terminal and keep running; 0 = one-shot
- load_val  input  WIDTH  start value, sampled when a load occurs
- term_val  input  WIDTH  terminal value, compared every RUN cycle
- q  output  WIDTH  current count
- t  output  WIDTH  toggle vector applied at the last edge (q_new XOR q_old)
- busy  output  1  1 in RUN or HOLD
- done  output  1  one-cycle pulse on terminal count
- wrap  output  1  one-cycle pulse on modulo wrap

## Operation
- FSM states:
  - IDLE: reset state; q is held.
  - RUN: counting.
  - HOLD: paused; q is frozen.
- Reset (rst=1 at an edge): state becomes IDLE. q, t, busy, done and wrap all become 0. Reset overrides every other input.
- IDLE:
  - start=1: q <= load_val, state becomes RUN.
  - start=0: no change.
  - stop is ignored.
- RUN, evaluated in priority order:
  1. stop=1: state becomes HOLD, q unchanged, no done.
  2. q == term_val: done <= 1.
     - auto_reload=1: q <= load_val, stay in RUN.
     - auto_reload=0: q holds term_val, state becomes IDLE.
  3. Otherwise: q <= q+1 when dir=1, or q-1 when dir=0, modulo 2^WIDTH.
     - wrap <= 1 on 15→0 (up) or 0→15 (down).
  - start is ignored in RUN.
- HOLD:
  - stop=1: stay in HOLD. stop wins over start.
  - stop=0 and start=1: return to RUN with no reload; counting continues from the frozen q.
- Direction and term_val may change mid-run and take effect on the next RUN cycle.
- Terminal case: if load_val == term_val, done fires on the first RUN cycle.
- Terminal is matched by equality only. If dir runs away from term_val, the counter wraps and reaches it modulo 16.
- Outputs other than q:
  - t <= q_next ^ q on every edge. t is 0 whenever q did not change.
  - busy <= 1 when next state is RUN or HOLD.
  - done and wrap are 0 on every edge where their condition is absent.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- Start latency: a start sampled at edge k gives q = load_val and busy = 1 after edge k.
- One count step per clock in RUN.
- Terminal latency:
  - done asserts after the edge where RUN sees q == term_val.
  - That is N+1 edges after the load edge, where N = steps from load_val to term_val in the current direction.
  - busy drops on that same edge in one-shot mode.
- Stop takes effect at the sampling edge. Resume counts on the edge after the resuming start.
- Reset mid-operation clears everything at that edge. No done or wrap pulse is generated on reset.

## Test plan
- Reset: rst=1 for 2 cycles mid-count → q=0, t=0, busy=0, done=0, wrap=0, state IDLE. start while rst=1 is ignored.
- One-shot up: load_val=3, term_val=7, dir=1, start pulse.
  - q = 3,4,5,6,7 on successive edges.
  - t=0111 on the 3→4 edge.
  - done=1 for exactly one cycle on the 5th edge after load; busy=0 on that edge; q stays 7.
- Down with wrap: load_val=2, term_val=14, dir=0.
  - q = 2,1,0,15,14.
  - wrap=1 only after the 0→15 edge, with t=1111 there.
  - done after the 5th edge.
- Stop/resume: during up count at q=5, stop=1 for 3 cycles.
  - q stays 5, t=0000, busy=1.
  - Then stop=0 with start=1: q=6 on the following edge. No reload occurs.
  - start=1 together with stop=1 in HOLD keeps HOLD.
- Auto-reload: load_val=14, term_val=1, dir=1, auto_reload=1.
  - q = 14,15,0,1,14,15,...
  - done pulses each time q goes 1→14; wrap pulses on each 15→0.
  - busy stays 1.
- Equal load/terminal: load_val=term_val=9, one-shot → done one edge after load, q=9, back to IDLE.
